// File: rtl/mem_pkg.sv
// Shared types and helpers for the latency-configurable word RAM.
// Holds the handshake FSM state encoding and the byte-lane geometry helper.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam int MEM_MIN_LATENCY = 1;

    // Number of low address bits that select a byte within one word.
    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word storage with per-byte-lane strobed write and registered read, both on the commit edge.
// Latency: read data valid one edge after rd_en; no backpressure. Optional preload under MEM_INIT_EN.
module mem_byte_array
    import mem_pkg::*;
#(
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 256,
    parameter int    IDX_W       = 8,
    parameter string INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

`ifdef MEM_INIT_EN
    initial begin
        for (int w = 0; w < DEPTH_WORDS; w++) mem[w] = '0;
    end
`endif

    // Contents are deliberately not reset; only the handshake logic is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (rd_en) rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_latency_ram.sv
// Word RAM with valid/ready request/response, LATENCY edges from accept to resp_valid, strobed writes, error flag.
// One transaction in flight; req_ready low from accept until the response handshake. Optional preload: MEM_INIT_EN.
module mem_latency_ram
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = lane_bits(DATA_WIDTH);
    localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    mem_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic commit;

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [BYTES-1:0]      lat_wstrb;

    logic                  c_we, c_err;
    logic [ADDR_WIDTH-1:0] c_addr, c_idx;
    logic [DATA_WIDTH-1:0] c_wdata, arr_rdata;
    logic [BYTES-1:0]      c_wstrb;
    logic                  rd_sel;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        commit     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == MEM_MIN_LATENCY) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A single-cycle build commits on the accept edge, so it must use the live request.
    always_comb begin
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else begin
            c_we    = lat_we;
            c_addr  = lat_addr;
            c_wdata = lat_wdata;
            c_wstrb = lat_wstrb;
        end
        c_idx = c_addr >> LANE_BITS;
        c_err = (|(c_addr & ADDR_WIDTH'(BYTES - 1))) || (c_idx >= ADDR_WIDTH'(DEPTH_WORDS));
    end

    mem_byte_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .wr_en (commit && c_we && !c_err),
        .rd_en (commit && !c_we && !c_err),
        .idx   (c_idx[IDX_W-1:0]),
        .wdata (c_wdata),
        .wstrb (c_wstrb),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rd_sel    <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
            end
            if (commit) begin
                rd_sel   <= !c_we && !c_err;
                resp_err <= c_err;
            end
        end
    end

    // The array read register only moves on a clean read, so the response holds while stalled.
    assign resp_rdata = rd_sel ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_latency_ram.sv
// Directed bench for mem_latency_ram: LATENCY=2 instance for function, LATENCY=1 and 4 instances for timing.
module tb_mem_latency_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        resp_valid[3];
    logic        resp_ready[3];
    logic [31:0] resp_rdata[3];
    logic        resp_err  [3];

    int checks = 0;
    int errors = 0;

    mem_latency_ram #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );
    mem_latency_ram #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );
    mem_latency_ram #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present a request and wait (bounded) until resp_valid is seen; resp_ready is left low.
    task automatic do_txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
        req_wdata[k] = wdata; req_wstrb[k] = wstrb; resp_ready[k] = 1'b0;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid[k] = 1'b0;
        end while (!resp_valid[k] && lat < 20);
        if (!resp_valid[k]) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout inst %0d addr %0h got no resp_valid expected within 20 cycles", k, addr);
        end
        rdata = resp_rdata[k];
        err   = resp_err[k];
    endtask

    task automatic finish_resp(input int k);
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
    endtask

    // Back-to-back reads with resp_ready high: measure accept-to-valid and accept period.
    task automatic measure(input int k, input int lat_exp);
        int a0, a1, v0;
        a0 = -1; a1 = -1; v0 = -1;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 32'h0; resp_ready[k] = 1'b1;
        for (int t = 0; t < 40 && a1 < 0; t++) begin
            if (resp_valid[k] && v0 < 0) begin
                v0 = t;
                chk($sformatf("b2b_err_L%0d", lat_exp), {31'd0, resp_err[k]}, 32'd0);
            end
            if (req_ready[k]) begin
                if (a0 < 0) a0 = t;
                else if (a1 < 0) a1 = t;
            end
            @(negedge clk);
        end
        req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
        chk($sformatf("accept_to_valid_L%0d", lat_exp), v0 - a0, lat_exp);
        chk($sformatf("accept_period_L%0d", lat_exp), a1 - a0, lat_exp + 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 32'h0,   32'h0000000A, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h0000000A, 1'b0};
        vecs[2]  = '{1'b1, 32'h4,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h4,   32'h00001122, 4'h3, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h4,   32'h0,        4'hF, 32'hDEAD1122, 1'b0};
        vecs[5]  = '{1'b0, 32'h6,   32'h0,        4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h0000000A, 1'b0};
        vecs[8]  = '{1'b1, 32'h4,   32'h99999999, 4'h0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h4,   32'h0,        4'h0, 32'hDEAD1122, 1'b0};
        vecs[10] = '{1'b1, 32'h8,   32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[13] = '{1'b1, 32'h1,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h0000000A, 1'b0};
        vecs[15] = '{1'b0, 32'h1,   32'h0,        4'h0, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 32'h4,   32'h00AB0000, 4'h4, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h4,   32'h0,        4'h0, 32'hDEAB1122, 1'b0};

        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0; req_wstrb[k] = '0; resp_ready[k] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_req_ready_%0d", k), {31'd0, req_ready[k]}, 32'd1);
            chk($sformatf("rst_resp_valid_%0d", k), {31'd0, resp_valid[k]}, 32'd0);
            chk($sformatf("rst_rdata_%0d", k), resp_rdata[k], 32'd0);
            chk($sformatf("rst_err_%0d", k), {31'd0, resp_err[k]}, 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 18; v++) begin
            do_txn(0, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, rd, er, lat);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
            chk($sformatf("vec%0d_latency", v), lat, 2);
            finish_resp(0);
        end

        // Response stall: outputs hold, and a request pulse during RESP is ignored.
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), {31'd0, resp_valid[0]}, 32'd1);
            chk($sformatf("stall%0d_rdata", i), resp_rdata[0], 32'h0000000A);
            chk($sformatf("stall%0d_err", i), {31'd0, resp_err[0]}, 32'd0);
            chk($sformatf("stall%0d_req_ready", i), {31'd0, req_ready[0]}, 32'd0);
            if (i == 1) begin
                req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0;
                req_wdata[0] = 32'h77; req_wstrb[0] = 4'hF;
            end
            if (i == 2) req_valid[0] = 1'b0;
        end
        finish_resp(0);
        chk("post_hs_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("post_hs_req_ready", {31'd0, req_ready[0]}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_valid", i), {31'd0, resp_valid[0]}, 32'd0);
        end
        do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("pulse_not_written", rd, 32'h0000000A);
        finish_resp(0);

        // Reset during WAIT of a write to 0x8 discards it.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8;
        req_wdata[0] = 32'h55; req_wstrb[0] = 4'hF;
        chk("pre_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("wait_req_ready", {31'd0, req_ready[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("wait_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("wait_rst_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("wait_rst_rdata", resp_rdata[0], 32'd0);
        chk("wait_rst_err", {31'd0, resp_err[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        chk("rst_discard_rdata", rd, 32'h11223344);
        finish_resp(0);

        measure(1, 1);
        measure(2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
